// File: rtl/l1_cache_pkg.sv
// Shared types and helpers for the direct-mapped L1 cache.
package l1_cache_pkg;
  localparam int C_S_BITS = 3;

  typedef logic [11-C_S_BITS:0] lc3b_c_tag;
  typedef logic [C_S_BITS-1:0]  lc3b_c_index;
  typedef logic [2:0]           lc3b_c_offset;
  typedef logic [127:0]         lc3b_c_block;
  typedef logic [15:0]          lc3b_pmem_addr;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_FILL
  } cache_state_e;

  // Merge the enabled byte lanes of wdata into word w of a line.
  function automatic lc3b_c_block merge_word(input lc3b_c_block line, input lc3b_c_offset w,
                                             input logic [1:0] be, input logic [15:0] wdata);
    lc3b_c_block r;
    r = line;
    if (be[0]) r[{w, 4'b0000} +: 8] = wdata[7:0];
    if (be[1]) r[{w, 4'b1000} +: 8] = wdata[15:8];
    return r;
  endfunction
endpackage

// File: rtl/l1_cache_control.sv
// Miss-handling FSM: IDLE serves hits, WRITEBACK evicts a dirty victim, FILL installs the line.
module cache_control
  import l1_cache_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic request,
  input  logic hit,
  input  logic dirty_victim,
  input  logic pmem_resp,
  output logic idle,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic load_line,
  output logic clr_dirty
);
  cache_state_e state_q, state_d;
  logic         gap_q, gap_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = 1'b0;
    idle       = 1'b0;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    load_line  = 1'b0;
    clr_dirty  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle = 1'b1;
        if (request) begin
          if (hit) mem_resp = 1'b1;
          else     state_d  = dirty_victim ? ST_WRITEBACK : ST_FILL;
        end
      end
      ST_WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          clr_dirty = 1'b1;
          gap_d     = 1'b1;
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        // First FILL cycle after a write-back is dead: strobes low, a lingering pmem_resp ignored.
        if (!gap_q) begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load_line = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1: tag/data arrays and datapath muxes.
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int S_BITS = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int NSETS = 1 << S_BITS;
  localparam int TAG_W = 12 - S_BITS;

  logic [NSETS-1:0]             valid_q, valid_d, dirty_q, dirty_d;
  logic [NSETS-1:0][TAG_W-1:0]  tag_q, tag_d;
  lc3b_c_block [NSETS-1:0]      data_q, data_d;
  logic [11:0]                  miss_addr_q, miss_addr_d;

  logic [TAG_W-1:0]  cur_tag;
  logic [S_BITS-1:0] cur_idx, live_idx;
  lc3b_c_offset      word;
  logic              idle, hit, dirty_victim, request;
  logic              load_line, clr_dirty, write_hit;
  logic              unused_addr_bit;

  assign unused_addr_bit = mem_address[0];

  // The line address is frozen while a miss is outstanding so a withdrawn
  // request still installs the line it started fetching.
  assign miss_addr_d = idle ? mem_address[15:4] : miss_addr_q;
  assign cur_tag     = miss_addr_d[11:S_BITS];
  assign cur_idx     = miss_addr_d[S_BITS-1:0];
  assign live_idx    = mem_address[3+S_BITS:4];
  assign word        = mem_address[3:1];

  assign request      = mem_read | mem_write;
  assign hit          = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign dirty_victim = valid_q[cur_idx] && dirty_q[cur_idx];

  cache_control u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .request      (request),
    .hit          (hit),
    .dirty_victim (dirty_victim),
    .pmem_resp    (pmem_resp),
    .idle         (idle),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .load_line    (load_line),
    .clr_dirty    (clr_dirty)
  );

  assign write_hit = mem_resp && mem_write && !reset;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (write_hit && (mem_byte_enable != 2'b00)) begin
      data_d[cur_idx]  = merge_word(data_q[cur_idx], word, mem_byte_enable, mem_wdata);
      dirty_d[cur_idx] = 1'b1;
    end
    if (clr_dirty && !reset) dirty_d[cur_idx] = 1'b0;
    if (load_line && !reset) begin
      data_d[cur_idx]  = pmem_rdata;
      tag_d[cur_idx]   = cur_tag;
      valid_d[cur_idx] = 1'b1;
      dirty_d[cur_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    tag_q       <= tag_d;
    data_q      <= data_d;
    miss_addr_q <= miss_addr_d;
  end

  always_comb begin
    pmem_address = '0;
    pmem_wdata   = '0;
    if (pmem_write) begin
      pmem_address = {tag_q[cur_idx], cur_idx, 4'b0000};
      pmem_wdata   = data_q[cur_idx];
    end else if (pmem_read) begin
      pmem_address = {cur_tag, cur_idx, 4'b0000};
    end
  end

  assign mem_rdata = data_q[live_idx][{word, 4'b0000} +: 16];
endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache with a set-level reference model and a physical-memory responder.
module tb_l1_cache;
  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  l1_cache #(.S_BITS(3)) dut (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-set state plus a sparse backing memory.
  logic [7:0]   mv, md;
  logic [8:0]   mt [8];
  logic [127:0] ml [8];
  logic [127:0] pmem_mem [logic [15:0]];

  int          n_wb, n_fill, resp_cyc, fill_resp_cyc, wb_resp_cyc;
  logic [15:0] first_wb_addr, first_wb_w2, first_fill_addr, last_rdata;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [15:0] a);
    logic [127:0] l;
    if (pmem_mem.exists(a)) return pmem_mem[a];
    for (int w = 0; w < 8; w++) l[16*w +: 16] = {a[15:4], 4'(w)};
    return l;
  endfunction

  task automatic model_write(input int i, input int w, input logic [1:0] be, input logic [15:0] wd);
    if (be[0]) ml[i][16*w +: 8]   = wd[7:0];
    if (be[1]) ml[i][16*w+8 +: 8] = wd[15:8];
    if (be != 2'b00) md[i] = 1'b1;
  endtask

  // Every cycle: mem_resp must be exactly "request present and the model holds the line".
  always @(negedge clk) begin : cmp
    int ci;
    logic exp_resp;
    #2;
    if (!reset) begin
      ci = int'(mem_address[6:4]);
      exp_resp = (mem_read || mem_write) && mv[ci] && (mt[ci] == mem_address[15:7]);
      chk_i("mem_resp", int'(mem_resp), int'(exp_resp));
      chk_i("strobe_excl", int'(pmem_read && pmem_write), 0);
      if (exp_resp && mem_read && !mem_write)
        chk("rdata", 128'(mem_rdata), 128'(ml[ci][16*int'(mem_address[3:1]) +: 16]));
    end
  end

  // One CPU access, called at a falling edge. lat = wait cycles before pmem_resp,
  // rlen = pmem_resp pulse width, cut >= 0 withdraws the request at that cycle.
  task automatic access(input bit wr, input bit both, input logic [15:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input int lat, input int rlen, input int cut);
    int idx, w, wcnt, rcnt, rleft, c;
    logic [8:0] tg;
    logic [15:0] vaddr, faddr;
    bit wb_ev, fill_ev, done, live, exp_miss, exp_dirty;
    idx = int'(a[6:4]); tg = a[15:7]; w = int'(a[3:1]);
    faddr = {a[15:4], 4'h0};
    exp_miss  = !(mv[idx] && mt[idx] == tg);
    exp_dirty = exp_miss && mv[idx] && md[idx];
    n_wb = 0; n_fill = 0; resp_cyc = -1; fill_resp_cyc = -1; wb_resp_cyc = -1;
    wcnt = 0; rcnt = 0; rleft = 0; done = 0; live = 1;
    mem_address = a; mem_read = !wr || both; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    for (c = 0; c < 100 && !done; c++) begin
      if (c == cut) begin mem_read = 0; mem_write = 0; live = 0; end
      #1;
      wb_ev = 0; fill_ev = 0;
      vaddr = {mt[idx], 3'(idx), 4'h0};
      if (rleft > 0) begin rleft--; pmem_resp = (rleft > 0); end
      if (live && mem_resp) begin resp_cyc = c; last_rdata = mem_rdata; end
      if (rleft == 0 && pmem_write) begin
        if (wcnt == 0) begin
          n_wb++;
          first_wb_addr = pmem_address; first_wb_w2 = pmem_wdata[47:32];
          chk("wb_addr", 128'(pmem_address), 128'(vaddr));
          chk("wb_data", pmem_wdata, ml[idx]);
        end
        wcnt++;
        if (wcnt > lat) begin
          pmem_resp = 1; rleft = rlen; wb_ev = 1; wb_resp_cyc = c; wcnt = 0;
        end
      end else if (rleft == 0 && pmem_read) begin
        if (rcnt == 0) begin
          n_fill++;
          first_fill_addr = pmem_address;
          chk("fill_addr", 128'(pmem_address), 128'(faddr));
          if (wb_resp_cyc >= 0) chk_i("wb_gap", c, wb_resp_cyc + 2);
          pmem_rdata = mem_line(faddr);
        end
        rcnt++;
        if (rcnt > lat) begin
          pmem_resp = 1; rleft = rlen; fill_ev = 1; fill_resp_cyc = c; rcnt = 0;
        end
      end
      @(posedge clk); #1;
      if (wb_ev) begin pmem_mem[vaddr] = ml[idx]; md[idx] = 0; end
      if (fill_ev) begin ml[idx] = pmem_rdata; mt[idx] = tg; mv[idx] = 1; md[idx] = 0; end
      if (live && resp_cyc == c) begin
        if (wr) model_write(idx, w, be, wd);
        mem_read = 0; mem_write = 0; live = 0; done = 1;
      end
      if (!live && !done && fill_resp_cyc >= 0 && c >= fill_resp_cyc + 1) done = 1;
      if (!done) @(negedge clk);
    end
    if (!done) chk_i("access_timeout", c, -1);
    pmem_resp = 0;
    chk_i("n_fill", n_fill, int'(exp_miss));
    chk_i("n_wb", n_wb, int'(exp_dirty));
    if (cut < 0) chk_i("resp_cycle", resp_cyc, exp_miss ? fill_resp_cyc + 1 : 0);
    else         chk_i("withdrawn_no_resp", resp_cyc, -1);
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    mv = '0; md = '0;
    reset = 1; mem_address = '0; mem_read = 0; mem_write = 0;
    mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk_i("rst_mem_resp", int'(mem_resp), 0);
    chk_i("rst_pmem_read", int'(pmem_read), 0);
    chk_i("rst_pmem_write", int'(pmem_write), 0);
    chk("rst_pmem_addr", 128'(pmem_address), 128'h0);
    @(negedge clk);

    // Clean fill after reset
    pmem_mem[16'h1230] = {64'h0, 16'hBEEF, 32'h0};
    access(0, 0, 16'h1234, 2'b00, 16'h0, 2, 1, -1);
    chk("lit_fill_addr", 128'(first_fill_addr), 128'h1230);
    chk("lit_rd_beef", 128'(last_rdata), 128'hBEEF);

    // Write hit, high byte only
    access(1, 0, 16'h1235, 2'b10, 16'hA500, 0, 1, -1);
    access(0, 0, 16'h1234, 2'b00, 16'h0, 0, 1, -1);
    chk("lit_rd_a5ef", 128'(last_rdata), 128'hA5EF);

    // Dirty eviction with a two-cycle pmem_resp
    access(0, 0, 16'h1334, 2'b00, 16'h0, 1, 2, -1);
    chk("lit_wb_addr", 128'(first_wb_addr), 128'h1230);
    chk("lit_wb_w2", 128'(first_wb_w2), 128'hA5EF);
    chk("lit_fill2_addr", 128'(first_fill_addr), 128'h1330);

    // Clean eviction back to the written-back line
    access(0, 0, 16'h1234, 2'b00, 16'h0, 0, 1, -1);
    chk("lit_wb_roundtrip", 128'(last_rdata), 128'hA5EF);

    // Write-allocate miss, low byte
    access(1, 0, 16'h1002, 2'b01, 16'h00CC, 1, 1, -1);
    access(0, 0, 16'h1002, 2'b00, 16'h0, 0, 1, -1);
    chk("lit_rd_10cc", 128'(last_rdata), 128'h10CC);

    // Empty byte enable: responds but leaves the line clean
    access(0, 0, 16'h0010, 2'b00, 16'h0, 0, 1, -1);
    access(1, 0, 16'h0012, 2'b00, 16'hFFFF, 0, 1, -1);
    access(0, 0, 16'h0012, 2'b00, 16'h0, 0, 1, -1);
    chk("lit_be00_data", 128'(last_rdata), 128'h0011);
    access(0, 0, 16'h0210, 2'b00, 16'h0, 0, 1, -1);

    // Read and write together act as a write, then a zero-latency dirty eviction
    access(1, 1, 16'h1234, 2'b11, 16'h1111, 0, 1, -1);
    access(0, 0, 16'h1234, 2'b00, 16'h0, 0, 1, -1);
    chk("lit_both_write", 128'(last_rdata), 128'h1111);
    access(0, 0, 16'h5234, 2'b00, 16'h0, 0, 1, -1);

    // Withdrawn mid-fill, then the re-issued request hits
    access(0, 0, 16'h4050, 2'b00, 16'h0, 3, 1, 2);
    access(0, 0, 16'h4050, 2'b00, 16'h0, 0, 1, -1);
    chk_i("lit_reissue_nofill", n_fill, 0);

    // Reset while a fill is waiting on pmem_resp
    mem_address = 16'h6060; mem_read = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (pmem_read) seen = 1;
      else @(negedge clk);
    end
    chk_i("rst_fill_started", int'(seen), 1);
    reset = 1;
    @(posedge clk); #1;
    mv = '0; md = '0;
    reset = 0; mem_read = 0;
    #1;
    chk_i("rst_mid_read", int'(pmem_read), 0);
    chk_i("rst_mid_write", int'(pmem_write), 0);
    chk_i("rst_mid_resp", int'(mem_resp), 0);
    @(negedge clk);
    access(0, 0, 16'h6060, 2'b00, 16'h0, 1, 1, -1);
    chk_i("lit_rst_refill", n_fill, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
